// File: rtl/serial_twos_complement_adder.sv
// Bit-serial two's-complement adder: one full-adder cell, LSB first, start/done handshake.
// Optional build macro SERIAL_ADD_SATURATE_EN clamps the result to the signed limit on overflow.
module serial_twos_complement_adder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic             last;
  logic             s_bit, c_nxt;
  logic [WIDTH-1:0] sum_res;
  logic [WIDTH-1:0] sum_out;
  logic             ovf_res;

  assign last    = (cnt == CNT_W'(WIDTH-1));
  assign s_bit   = a_sh[0] ^ b_sh[0] ^ c;
  assign c_nxt   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign sum_res = {s_bit, sum_sh[WIDTH-1:1]};
  // c still holds the carry into the MSB on the last bit, so no separate cin flop is needed.
  assign ovf_res = c ^ c_nxt;

`ifdef SERIAL_ADD_SATURATE_EN
  // On overflow both operands share a sign; a_sh[0] is that sign bit on the last cycle.
  assign sum_out = !ovf_res ? sum_res :
                   a_sh[0]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum_out = sum_res;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          a_sh   <= a;
          b_sh   <= b;
          sum_sh <= '0;
          cnt    <= '0;
          c      <= 1'b0;
        end
        ADD: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_res;
          c      <= c_nxt;
          cnt    <= cnt + CNT_W'(1);
          // Results land on the edge entering DONE so they are visible alongside done.
          if (last) begin
            sum      <= sum_out;
            carry    <= c_nxt;
            overflow <= ovf_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_twos_complement_adder.sv
// Randomized and directed check of serial_twos_complement_adder against an arithmetic model.
module tb_serial_twos_complement_adder;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         start;
  logic [W-1:0] sum;
  logic         carry, overflow, busy, done;

  int errs = 0;
  int checks = 0;

  // Last committed expected results; outputs must hold these until the next done.
  int hold_sum = 0, hold_carry = 0, hold_ovf = 0;

  serial_twos_complement_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start),
    .sum(sum), .carry(carry), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed/unsigned views of the operands.
  task automatic model(input int av, input int bv, output int es, output int ec, output int eo);
    int sa, sb, ss, raw;
    raw = av + bv;
    sa  = (av >= M/2) ? av - M : av;
    sb  = (bv >= M/2) ? bv - M : bv;
    ss  = sa + sb;
    ec  = (raw >= M) ? 1 : 0;
    eo  = (ss > M/2 - 1 || ss < -(M/2)) ? 1 : 0;
    es  = raw % M;
`ifdef SERIAL_ADD_SATURATE_EN
    if (eo == 1) es = (ss > 0) ? (M/2 - 1) : (M/2);
`endif
  endtask

  // Drives one start at the next negedge and returns at the negedge of the done cycle.
  task automatic do_op(input int av, input int bv, input string tag);
    int es, ec, eo, n;
    model(av, bv, es, ec, eo);
    @(negedge clk);
    a = W'(av); b = W'(bv); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    n = 1;
    while (!done && n < 20) begin
      chk({tag, " busy"}, busy, 1);
      chk({tag, " hold"}, sum, hold_sum);
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, W + 1);
    chk({tag, " sum"}, sum, es);
    chk({tag, " carry"}, carry, ec);
    chk({tag, " ovf"}, overflow, eo);
    chk({tag, " busy@done"}, busy, 1);
    hold_sum = es; hold_carry = ec; hold_ovf = eo;
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst carry", carry, 0);
    chk("rst ovf", overflow, 0);
    rst = 1'b0;

    do_op(3, 4, "3+4");
    @(negedge clk);
    chk("pulse done", done, 0);
    chk("pulse busy", busy, 0);
    chk("idle hold", sum, hold_sum);
    do_op(7, 1, "7+1");
    do_op(15, 15, "-1+-1");
    do_op(8, 15, "-8+-1");
    do_op(0, 0, "0+0");
    do_op(7, 7, "7+7");
    do_op(8, 8, "-8+-8");

    // Start while busy is ignored; a single done for the first operation.
    @(negedge clk);
    a = 4'd2; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd5; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        dn++;
        chk("ign sum", sum, 4);
      end
      @(negedge clk);
    end
    chk("ign done count", dn, 1);
    hold_sum = 4; hold_carry = 0; hold_ovf = 0;

    // Back-to-back: second start issued in the cycle right after done.
    do_op(2, 3, "b2b first");
    do_op(5, 5, "b2b second");

    // Reset mid-operation aborts with no done.
    @(negedge clk);
    a = 4'd6; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 0);
    chk("abort carry", carry, 0);
    chk("abort ovf", overflow, 0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("abort no done", dn, 0);
    hold_sum = 0; hold_carry = 0; hold_ovf = 0;
    do_op(1, 1, "post-rst");

    for (int i = 0; i < 40; i++) begin
      int ra, rb;
      ra = $urandom_range(0, M - 1);
      rb = $urandom_range(0, M - 1);
      do_op(ra, rb, "rand");
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_twos_complement_adder.md
Name: serial_twos_complement_adder

Overview:
- Bit-serial adder for WIDTH-bit two's-complement operands, processing one bit per clock, LSB first.
- Inverse companion to the team's combinational two's-complement subtractor: performs addition.
- Trades latency for a single full-adder cell and one carry flop.
- Used where an area-cheap add is wanted behind a start/done handshake; reports unsigned carry-out and signed overflow.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 2).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  augend; sampled only on an accepted start.
- b  input  WIDTH  addend; sampled only on an accepted start.
- start  input  1  request; accepted only when busy=0.
- sum  output  WIDTH  result; valid from the done cycle and held until the next accepted start.
- carry  output  1  carry-out of the MSB (unsigned overflow); held like sum.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB); held like sum.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse when results become valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: sum=0, carry=0, overflow=0, busy=0, done=0, state=IDLE, counter=0, internal carry flop=0, shift registers=0.
- Reset mid-operation: abort immediately to IDLE with all of the above reset values. No done is generated for the aborted operation.
- State IDLE:
  - start=1: load a_sh<=a, b_sh<=b, c<=0, cnt<=0, clear sum_sh; go to ADD. busy rises next cycle.
  - Otherwise: hold all outputs.
- State ADD, one bit per cycle:
  - s = a_sh[0]^b_sh[0]^c.
  - c <= majority(a_sh[0], b_sh[0], c).
  - a_sh and b_sh shift right by 1.
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
  - cnt <= cnt+1.
  - On the cycle processing bit WIDTH-1 (cnt==WIDTH-1): capture cin_msb = c (the carry into the MSB, before update), then go to DONE.
- State DONE, exactly one cycle:
  - sum <= sum_sh, carry <= c, overflow <= cin_msb ^ c, done=1, busy=1; next state IDLE.
  - The output registers update on entry, so sum/carry/overflow and done are all visible in this same cycle.
- Latency: start sampled at edge 0 → done high during cycle WIDTH+1; next start is accepted in the cycle after done (earliest edge WIDTH+2).
- start while busy=1 (ADD or DONE): ignored, no queuing. Operands presented then are not captured.
- start in IDLE in the cycle immediately after done: accepted normally.
- Result outputs hold their last values through a new ADD phase until that operation's DONE.
- Arithmetic: result is modulo 2^WIDTH. carry and overflow are independent flags; both can be 1 (e.g., most-negative + negative).

Optional Feature:
- Macro: SERIAL_ADD_SATURATE_EN.
- Defined: in DONE, if overflow=1, sum is clamped to the signed limit.
  - Operands' sign bit 0 → 0111..1 (max positive).
  - Operands' sign bit 1 → 1000..0 (min negative). Both operands share the sign whenever overflow occurs.
  - carry and overflow still report the raw, unclamped condition.
- Undefined: sum is the wrapped modulo result. No saturation logic is generated.

Test Plan:
- WIDTH=4, a=3, b=4, start one cycle → done in cycle 5; sum=7, carry=0, overflow=0; busy high cycles 1-5.
- a=7, b=1 → sum=4'b1000, carry=0, overflow=1. With SERIAL_ADD_SATURATE_EN defined: sum=4'b0111, overflow=1.
- a=4'hF, b=4'hF (-1 + -1) → sum=4'hE, carry=1, overflow=0.
- a=4'h8, b=4'hF (-8 + -1) → sum=4'h7, carry=1, overflow=1. With SERIAL_ADD_SATURATE_EN defined: sum=4'h8.
- Start a=2, b=2; assert start again at cycle 2 with a=5, b=5 → second start ignored, sum=4, single done pulse; then start a=5, b=5 the cycle after done → sum=4'hA, overflow=1.
- Start a=6, b=1; assert rst at cycle 3 → next cycle busy=0, done=0, sum=0, carry=0, overflow=0; no done pulse follows. A fresh start a=1, b=1 → sum=2.
